// File: rtl/sum_uart_pkg.sv
// Shared UART definitions for the sum transmit path
// and the future receiver stage.
package sum_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned FRAME_BITS =
    1 + DATA_BITS + STOP_BITS;
  localparam int unsigned FRAME_BITS_PAR =
    FRAME_BITS + 1;

  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick marks the last cycle of a bit,
// the counter reloads itself on every tick.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = !restart && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sum_uart_tx.sv
// UART transmitter fed by the sum/latch stage through a
// one-entry holding register; back-to-back frames are gapless.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       ready_q;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick;
  logic       restart;
  logic       accept;
  logic       load;

  assign restart = (state_q == ST_IDLE);
  assign accept  = in_valid && ready_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == LAST_BIT) begin
            if (PARITY_EN) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // a pending byte starts its frame on the same edge
    if (load) begin
      state_d = ST_START;
      tx_d    = 1'b0;
      shift_d = hold_q;
      idx_d   = '0;
      par_d   = (^hold_q) ^ PARITY_ODD;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = in_data;
    end
    busy_d = (state_d != ST_IDLE) || hold_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      ready_q     <= !hold_full_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready   = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/sum_uart_tx.md
SUM_UART_TX -- requirements
Module: sum_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per UART bit (10 MHz / 115200 baud).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, meaning 1 inserts a parity bit after the data bits.
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity; it is ignored when PARITY_EN=0.
REQ-004 clk  input  1  the single clock; all state is rising-edge clocked.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 in_valid  input  1  the upstream sum/latch stage presents a byte.
REQ-007 in_data  input  8  the latched sum byte to transmit.
REQ-008 in_ready  output  1  the holding register is empty and can accept a byte.
REQ-009 tx  output  1  UART serial line; idles high.
REQ-010 busy  output  1  a frame is being shifted or a byte is pending.
REQ-011 frame_done  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-012 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into a one-entry holding register.
REQ-013 in_ready SHALL be a registered output equal to NOT hold_full; it SHALL NOT depend combinationally on in_valid.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 From IDLE with hold_full=1, the FSM SHALL load the shift register on the next edge, clear hold_full, enter START and drive tx=0; tx falls exactly one cycle after the accepting edge.
REQ-016 Each bit (start, data, parity, stop) SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a counter that reloads at each bit boundary.
REQ-017 DATA SHALL shift 8 bits LSB first using a 3-bit index; after bit 7 the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-018 The parity bit SHALL be the XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-019 STOP SHALL drive tx=1 for one bit time; frame_done SHALL pulse high on the cycle after the final STOP cycle.
REQ-020 At the end of STOP with hold_full=1, the FSM SHALL go directly to START with no idle gap, so back-to-back frames are contiguous.
REQ-021 At the end of STOP with hold_full=0, the FSM SHALL return to IDLE with tx=1.
REQ-022 Total frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles when PARITY_EN=1.
REQ-023 An accept while the engine is mid-frame SHALL fill the holding register; in_ready SHALL be 0 until the engine loads that byte.
REQ-024 When the engine loads on the same edge that hold_full would be set, the load SHALL take priority and no byte SHALL be lost or duplicated; this cannot coincide with an accept because in_ready=0 while hold_full=1.
REQ-025 busy SHALL equal (state != IDLE) OR hold_full, and SHALL be registered.
REQ-026 tx SHALL be driven directly from a flop (glitch-free).
REQ-027 in_data SHALL be ignored when no transfer occurs; a change on in_data mid-frame SHALL NOT alter the frame in flight.

Reset
REQ-028 While rst_n=0, the outputs SHALL be tx=1, in_ready=0, busy=0 and frame_done=0, and the state SHALL be IDLE with the counters, shift register and hold_full all cleared.
REQ-029 On the first edge after rst_n rises, in_ready SHALL become 1.
REQ-030 Reset asserted mid-frame SHALL return tx to 1 immediately (asynchronously), abort the frame and discard the pending byte; no frame_done pulse SHALL be produced.

Structure
REQ-031 Package sum_uart_pkg SHALL hold the FSM state enum, the DATA_BITS=8 constant and the frame-length constants, shared with the future receiver stage.
REQ-032 Bit timing SHALL live in one sub-module, uart_baud_tick (parameter CLKS_PER_BIT; inputs clk, rst_n, restart; output tick).
REQ-033 Elaboration SHALL fail if CLKS_PER_BIT < 2.

Verification (CLKS_PER_BIT=4)
REQ-034 Single byte: accept 0xA5 while idle -> tx low 1 cycle later; LSB-first bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop high; frame_done pulses at cycle 41; busy low afterwards.
REQ-035 Back-to-back: accept 0x3C, then 0xC3 mid-frame -> in_ready=0 until the second load; second start bit immediately follows the first stop bit; 80 contiguous cycles; two frame_done pulses.
REQ-036 Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1, frame 44 cycles; PARITY_ODD=1 -> parity bit 0.
REQ-037 Held valid: keep in_valid=1 with in_data stepping 0x01..0x04 -> exactly four frames transmitted, in order, none dropped or repeated.
REQ-038 Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 the same cycle; after release, no residual frame, busy=0, and the next accepted byte is sent correctly.
